// File: rtl/init_sequencer_if.sv
// Sequencer-side bundle: per-channel start/done handshakes, register-read handshake and status outputs.
// master = sequencer, slave = init engines / read engine / display.
interface init_sequencer_if #(
    parameter int NUM_CH = 2
);
    logic [NUM_CH-1:0] start_out;
    logic [NUM_CH-1:0] done_in;
    logic              rd_req;
    logic              rd_start;
    logic              rd_done;
    logic              busy;
    logic              all_done;
    logic              error;
    logic [2:0]        err_ch;
    logic [NUM_CH-1:0] fail_mask;
    logic              rd_err;
    logic [3:0]        state_out;

    modport master (
        output start_out, rd_start, busy, all_done, error, err_ch, fail_mask, rd_err, state_out,
        input  done_in, rd_req, rd_done
    );

    modport slave (
        input  start_out, rd_start, busy, all_done, error, err_ch, fail_mask, rd_err, state_out,
        output done_in, rd_req, rd_done
    );
endinterface

// File: rtl/init_sequencer.sv
// Power-up sequencer: startup delay, then per-channel start/done with timeout, retry and settle, then on-demand reads.
// INIT_SEQ_ABORT_ON_FAIL_EN: a channel that exhausts its retries parks the FSM in ERROR instead of skipping the channel.
module init_sequencer #(
    parameter int NUM_CH        = 2,
    parameter int TICK_DIV      = 50,
    parameter int STARTUP_DELAY = 1000000,
    parameter int SETTLE_DELAY  = 1000,
    parameter int TIMEOUT       = 5000,
    parameter int MAX_RETRY     = 2,
    parameter int CNT_W         = 32
) (
    input logic                clk,
    input logic                reset,
    init_sequencer_if.master   bus
);
    typedef enum logic [3:0] {
        ST_STARTUP  = 4'd1,
        ST_CH_START = 4'd2,
        ST_CH_WAIT  = 4'd3,
        ST_CH_SETTLE= 4'd4,
        ST_READY    = 4'd5,
        ST_RD_START = 4'd6,
        ST_RD_WAIT  = 4'd7,
        ST_ERROR    = 4'd8
    } state_t;

    state_t             r_state, w_state_nxt;
    logic [CNT_W-1:0]   r_pre, r_cnt;
    logic [2:0]         r_ch, w_ch_nxt;
    logic [7:0]         r_retry, w_retry_nxt;
    logic               r_seen, w_seen_nxt;
    logic               r_rd_req_q;
    logic [NUM_CH-1:0]  r_start, r_fail_mask;
    logic               r_rd_start, r_all_done, r_error, r_rd_err;
    logic [2:0]         r_err_ch;

    logic               w_tick, w_done_sel, w_rd_rise;
    logic [NUM_CH-1:0]  w_ch_sel;
    logic               w_fail, w_done_set, w_rd_err_set, w_rd_err_clr;

    assign w_tick     = (r_pre == CNT_W'(TICK_DIV - 1));
    assign w_ch_sel   = NUM_CH'(1) << r_ch;
    assign w_done_sel = |(bus.done_in & w_ch_sel);
    assign w_rd_rise  = bus.rd_req & ~r_rd_req_q;

    always_comb begin
        w_state_nxt  = r_state;
        w_ch_nxt     = r_ch;
        w_retry_nxt  = r_retry;
        w_seen_nxt   = r_seen;
        w_fail       = 1'b0;
        w_done_set   = 1'b0;
        w_rd_err_set = 1'b0;
        w_rd_err_clr = 1'b0;
        case (r_state)
            ST_STARTUP: begin
                if (r_cnt == CNT_W'(STARTUP_DELAY)) begin
                    w_state_nxt = ST_CH_START;
                    w_ch_nxt    = 3'd0;
                    w_retry_nxt = 8'd0;
                end
            end
            ST_CH_START: begin
                // A done level that never dropped after start is stale and must not be accepted.
                w_seen_nxt  = ~w_done_sel;
                w_state_nxt = ST_CH_WAIT;
            end
            ST_CH_WAIT: begin
                if (!w_done_sel) w_seen_nxt = 1'b1;
                if (w_done_sel && r_seen) begin
                    w_state_nxt = ST_CH_SETTLE;
                end else if (r_cnt == CNT_W'(TIMEOUT)) begin
                    if (r_retry < 8'(MAX_RETRY)) begin
                        w_retry_nxt = r_retry + 8'd1;
                        w_state_nxt = ST_CH_START;
                    end else begin
                        w_fail      = 1'b1;
`ifdef INIT_SEQ_ABORT_ON_FAIL_EN
                        w_state_nxt = ST_ERROR;
`else
                        w_state_nxt = ST_CH_SETTLE;
`endif
                    end
                end
            end
            ST_CH_SETTLE: begin
                if (r_cnt == CNT_W'(SETTLE_DELAY)) begin
                    if (r_ch == 3'(NUM_CH - 1)) begin
                        w_state_nxt = ST_READY;
                        w_done_set  = 1'b1;
                    end else begin
                        w_ch_nxt    = r_ch + 3'd1;
                        w_retry_nxt = 8'd0;
                        w_state_nxt = ST_CH_START;
                    end
                end
            end
            ST_READY: begin
                if (w_rd_rise) begin
                    w_state_nxt  = ST_RD_START;
                    w_rd_err_clr = 1'b1;
                end
            end
            ST_RD_START: begin
                w_seen_nxt  = ~bus.rd_done;
                w_state_nxt = ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
                if (!bus.rd_done) w_seen_nxt = 1'b1;
                if (bus.rd_done && r_seen) begin
                    w_state_nxt = ST_READY;
                end else if (r_cnt == CNT_W'(TIMEOUT)) begin
                    w_rd_err_set = 1'b1;
                    w_state_nxt  = ST_READY;
                end
            end
            ST_ERROR: w_state_nxt = ST_ERROR;
            default:  w_state_nxt = ST_STARTUP;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= ST_STARTUP;
            r_pre       <= '0;
            r_cnt       <= '0;
            r_ch        <= 3'd0;
            r_retry     <= 8'd0;
            r_seen      <= 1'b0;
            r_rd_req_q  <= 1'b0;
            r_start     <= '0;
            r_rd_start  <= 1'b0;
            r_fail_mask <= '0;
            r_all_done  <= 1'b0;
            r_error     <= 1'b0;
            r_err_ch    <= 3'd0;
            r_rd_err    <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_pre      <= w_tick ? '0 : r_pre + CNT_W'(1);
            if (w_state_nxt != r_state)
                r_cnt <= '0;
            else if (w_tick)
                r_cnt <= r_cnt + CNT_W'(1);
            r_ch       <= w_ch_nxt;
            r_retry    <= w_retry_nxt;
            r_seen     <= w_seen_nxt;
            r_rd_req_q <= bus.rd_req;
            // Pulses are registered from the next state so they coincide with the START states.
            r_start    <= (w_state_nxt == ST_CH_START) ? (NUM_CH'(1) << w_ch_nxt) : '0;
            r_rd_start <= (w_state_nxt == ST_RD_START);
            if (w_fail) begin
                r_fail_mask <= r_fail_mask | w_ch_sel;
                r_error     <= 1'b1;
                r_err_ch    <= r_ch;
            end
            if (w_done_set) r_all_done <= 1'b1;
            if (w_rd_err_set)
                r_rd_err <= 1'b1;
            else if (w_rd_err_clr)
                r_rd_err <= 1'b0;
        end
    end

    assign bus.start_out = r_start;
    assign bus.rd_start  = r_rd_start;
    assign bus.fail_mask = r_fail_mask;
    assign bus.all_done  = r_all_done;
    assign bus.error     = r_error;
    assign bus.err_ch    = r_err_ch;
    assign bus.rd_err    = r_rd_err;
    assign bus.state_out = r_state;
    assign bus.busy      = !((r_state == ST_READY) || (r_state == ST_ERROR));
endmodule

// File: doc/init_sequencer.md
Name: init_sequencer

Overview:
Parametrised power-up and command sequencer for the HDMI/camera bring-up path. After a programmable startup delay, it brings up NUM_CH peripheral init engines (ADV7513 init, camera init, ...) one after another over start/done handshakes, with per-channel timeout, retry and settle delay. Once sequencing ends, it services on-demand register-read requests from a user button. Status outputs drive the LEDs and the 7-segment state display.

Parameters:
NUM_CH, 2, number of sequenced init channels (1..8); channel 0 runs first.
TICK_DIV, 50, clk cycles per internal delay tick (50 gives 1 us at 50 MHz).
STARTUP_DELAY, 1000000, ticks to wait after reset before channel 0.
SETTLE_DELAY, 1000, ticks to wait after each channel's done before the next channel starts.
TIMEOUT, 5000, ticks to wait for done before declaring a timeout.
MAX_RETRY, 2, re-issues of start per channel after a timeout.
CNT_W, 32, width of the tick counter; must hold the largest delay.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-low reset
start_out  out  NUM_CH  one-cycle start pulse per channel
done_in  in  NUM_CH  per-channel done level
rd_req  in  1  user read request (level; acted on at rising edge)
rd_start  out  1  one-cycle start pulse to the register-read engine
rd_done  in  1  register-read engine done level
busy  out  1  high unless in READY or ERROR
all_done  out  1  sequence finished (sticky until reset)
error  out  1  any channel failed (sticky until reset)
err_ch  out  3  index of the last channel that failed
fail_mask  out  NUM_CH  per-channel failure flags (sticky)
rd_err  out  1  last read timed out; cleared on the next accepted rd_req
state_out  out  4  current state encoding, for the 7-segment display

Behaviour:
- Reset (reset==0 at posedge clk): state=STARTUP.
  - All outputs are 0 except busy=1 and state_out=1.
  - Prescaler, tick counter, channel index and retry count are cleared.
- Prescaler:
  - Counts 0..TICK_DIV-1.
  - When it is at TICK_DIV-1, tick=1 for one clk.
  - Runs freely and is not cleared on state change.
- Tick counter:
  - Increments on tick.
  - Cleared on every state transition.
  - A delay D is complete when the count == D; D=0 completes on the cycle after entry.
- States (encoding in parentheses; state_out carries this value):
  - STARTUP (1): when the STARTUP_DELAY count is reached -> CH_START with ch=0, retry=0.
  - CH_START (2): start_out[ch]=1 for exactly this cycle -> CH_WAIT.
    - Also clears the seen_low flag, then sets it if done_in[ch]==0 this cycle.
  - CH_WAIT (3): seen_low is set on any cycle where done_in[ch]==0.
    - done_in[ch]==1 with seen_low set -> CH_SETTLE. A stale done that never went low is ignored.
    - TIMEOUT reached with retry<MAX_RETRY -> retry++, then CH_START.
    - TIMEOUT reached with retries exhausted -> fail_mask[ch]=1, error=1, err_ch=ch, then CH_SETTLE (default build).
    - Done and timeout in the same cycle: done wins.
  - CH_SETTLE (4): when the SETTLE_DELAY count is reached:
    - ch==NUM_CH-1 -> READY and all_done=1.
    - Otherwise ch++, retry=0, then CH_START.
  - READY (5): rd_req rising edge (registered previous value 0, current 1) -> RD_START and rd_err=0.
    - The edge register updates every cycle in every state. A request held high across entry to READY does not fire; rising edges outside READY are dropped.
  - RD_START (6): rd_start=1 for one cycle -> RD_WAIT. The same seen_low rule applies, using rd_done.
  - RD_WAIT (7): valid rd_done -> READY.
    - TIMEOUT reached -> rd_err=1, then READY. There is no retry for reads.
  - ERROR (8): used only with the optional feature; held until reset, busy=0.
- Undefined state encodings go to STARTUP on the next clk (safe encoding).
- All outputs are registered except state_out and busy, which decode the state register directly.

Optional Feature:
Macro INIT_SEQ_ABORT_ON_FAIL_EN.
- Defined: a channel whose retries are exhausted sets fail_mask[ch], error and err_ch, then goes to ERROR (8). Later channels are never started, all_done stays 0 and read requests are ignored.
- Undefined: the failed channel is skipped, the sequence continues and READY is reached as normal.

Test Plan:
Setup: NUM_CH=2, TICK_DIV=2, STARTUP_DELAY=4, SETTLE_DELAY=2, TIMEOUT=10, MAX_RETRY=1.
1. Nominal: release reset; done_in[i] goes 0->1 five clk after start_out[i].
   - Exactly one start_out[0] pulse ~8 clk after reset release, and start_out[1] ~4 clk after done_in[0].
   - Ends with all_done=1, busy=0, state_out=5, fail_mask=2'b00, error=0.
2. Timeout with retry: done_in[0] held 0.
   - start_out[0] pulses twice, ~20 clk apart.
   - Then fail_mask=2'b01, error=1, err_ch=0; channel 1 still runs and all_done=1.
3. Stale done: done_in[1] held 1 from reset.
   - Not accepted; after 2 pulses, fail_mask[1]=1.
   - Repeat with done_in[1] dropped for 1 clk after start, then raised -> accepted, fail_mask[1]=0.
4. Read: in READY, pulse rd_req 0->1; rd_done rises 3 clk after rd_start.
   - One rd_start pulse, then READY with rd_err=0.
   - rd_req held high -> no second pulse.
   - rd_done never asserted -> rd_err=1 after 10 ticks.
5. Reset mid-operation: assert reset in CH_WAIT of channel 1.
   - Next edge: start_out=0, fail_mask=0, state_out=1.
   - After release the sequence restarts at channel 0.
6. INIT_SEQ_ABORT_ON_FAIL_EN defined, stimulus of scenario 2.
   - state_out=8, busy=0, start_out[1] never pulses, all_done=0.
   - An rd_req edge produces no rd_start.
